ibex_mem_req_arbiter: RTL
=========================

// Module: ibex_mem_req_arbiter
// PURPOSE
//  N-channel arbiter for the Ibex request/grant/rvalid memory protocol: merges NUM_CH upstream
//  requesters onto one downstream port with a round-robin grant. Routes in-order responses back
//  through a channel-ID FIFO of depth MAX_OUTSTANDING. Sits between DV request agents (or core
//  LSU/IF ports) and a shared memory model or response agent.
// PARAMETERS
//  NUM_CH          2   number of upstream channels (>=2)
//  ADDR_WIDTH      32  address width
//  DATA_WIDTH      32  data width; byte-enable width is DATA_WIDTH/8
//  INTG_WIDTH      7   integrity bits carried with wdata/rdata
//  MAX_OUTSTANDING 4   max granted-but-unanswered requests (>=1); ID FIFO depth
// PORTS
//  clk_i           in   1                 clock
//  rst_ni          in   1                 async reset, active low
//  ch_req_i        in   NUM_CH            per-channel request
//  ch_gnt_o        out  NUM_CH            per-channel grant
//  ch_addr_i       in   NUM_CH*ADDR_WIDTH  packed per-channel addr
//  ch_we_i         in   NUM_CH            per-channel write enable
//  ch_be_i         in   NUM_CH*DATA_WIDTH/8  per-channel byte enables
//  ch_wdata_i      in   NUM_CH*DATA_WIDTH  per-channel write data
//  ch_wintg_i      in   NUM_CH*INTG_WIDTH  per-channel write integrity
//  ch_rvalid_o     out  NUM_CH            per-channel response valid
//  ch_rdata_o      out  DATA_WIDTH        read data, broadcast to all channels
//  ch_rintg_o      out  INTG_WIDTH        read integrity, broadcast
//  ch_err_o        out  1                 response error, broadcast
//  out_req_o / out_gnt_i / out_addr_o / out_we_o / out_be_o / out_wdata_o / out_wintg_o
//                  downstream request side; same widths as one channel
//  out_rvalid_i / out_rdata_i / out_rintg_i / out_err_i   downstream response side
//  spurious_rsp_o  out  1                 sticky: rvalid seen with no outstanding ID (see CONFIG)
// BEHAVIOUR
//  - Reset: out_req_o=0, ch_gnt_o=0, ch_rvalid_o=0, FIFO empty, rr pointer=0, lock clear,
//    spurious_rsp_o=0. Reset mid-transaction discards all outstanding IDs; later rvalids are spurious.
//  - States: IDLE (no lock) / LOCKED (channel held). In IDLE with FIFO not full, select the first
//    requesting channel at or after the rr pointer (wrapping). Drive out_req_o and the mux outputs
//    combinationally from the selected channel.
//  - If out_gnt_i=0, latch the lock. LOCKED keeps the same channel until grant, as the protocol
//    requires stable addr/req until gnt. An upstream req drop while locked is a protocol violation;
//    the block holds the lock regardless.
//  - Grant: ch_gnt_o[sel] = out_req_o & out_gnt_i. On grant: push sel into FIFO, rr pointer <= sel+1
//    mod NUM_CH, go to IDLE. Zero-cycle grant: req and gnt in the same cycle is one transaction.
//  - FIFO full: out_req_o=0 (no lock taken), even if out_rvalid_i pops in that same cycle. This
//    keeps rvalid off the req path, so the throughput limit is MAX_OUTSTANDING.
//  - Response: out_rvalid_i with FIFO non-empty asserts ch_rvalid_o[head] in the same cycle (zero
//    latency, combinational) and pops. rdata/rintg/err pass straight through.
//  - Simultaneous push and pop: both happen, and occupancy is unchanged.
//  - A response in the same cycle as the grant of the first outstanding request is spurious,
//    because the push is not yet visible.
//  - Occupancy counter is $clog2(MAX_OUTSTANDING+1) bits. Pointers wrap modulo MAX_OUTSTANDING.
// CONFIGURATION
//  IBEX_MEM_ARB_SPURIOUS_CHK_EN defined:
//    - out_rvalid_i with FIFO empty sets spurious_rsp_o (sticky until reset).
//    - The response is not routed: all ch_rvalid_o stay 0.
//    - A simulation $error is raised.
//  Undefined:
//    - spurious_rsp_o tied 0 and no check logic is built.
//    - out_rvalid_i with FIFO empty is silently dropped.
// TESTING
//  1. NUM_CH=2, both req every cycle, out_gnt_i=1, rvalid 1 cycle later -> grants alternate
//     ch0,ch1,ch0,..., and each rvalid goes to the matching channel.
//  2. ch1 req, out_gnt_i held 0 for 3 cycles, ch0 raises req in cycle 1 -> out_addr_o stays
//     ch1's for 4 cycles, and ch1 is granted first.
//  3. MAX_OUTSTANDING=4, 4 grants with no rvalid -> out_req_o=0 while full. The rvalid in the
//     full cycle pops ch-head, and the next request is issued the cycle after.
//  4. Push and pop in the same cycle at occupancy 2 -> occupancy stays 2, and IDs remain in order.
//  5. rst_ni pulsed low with 3 outstanding, then rvalid -> with macro: spurious_rsp_o=1 and no
//     ch_rvalid_o; without macro: dropped.
//  6. NUM_CH=4, only ch3 requesting after pointer=3 grant -> ch3 granted again; pointer wraps to 0.

Source files
------------

// File: rtl/ibex_mem_req_arbiter.sv
// ibex_mem_req_arbiter: round-robin merge of NUM_CH req/gnt/rvalid ports.
// Ports: clk_i, rst_ni; ch_* upstream (packed per channel), out_* downstream,
// spurious_rsp_o (sticky, only with IBEX_MEM_ARB_SPURIOUS_CHK_EN defined).
module ibex_mem_req_arbiter #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned INTG_WIDTH      = 7,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH-1:0]            ch_req_i,
  output logic [NUM_CH-1:0]            ch_gnt_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i,
  input  logic [NUM_CH-1:0]            ch_we_i,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] ch_be_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata_i,
  input  logic [NUM_CH*INTG_WIDTH-1:0] ch_wintg_i,
  output logic [NUM_CH-1:0]            ch_rvalid_o,
  output logic [DATA_WIDTH-1:0]        ch_rdata_o,
  output logic [INTG_WIDTH-1:0]        ch_rintg_o,
  output logic                         ch_err_o,
  output logic                         out_req_o,
  input  logic                         out_gnt_i,
  output logic [ADDR_WIDTH-1:0]        out_addr_o,
  output logic                         out_we_o,
  output logic [DATA_WIDTH/8-1:0]      out_be_o,
  output logic [DATA_WIDTH-1:0]        out_wdata_o,
  output logic [INTG_WIDTH-1:0]        out_wintg_o,
  input  logic                         out_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        out_rdata_i,
  input  logic [INTG_WIDTH-1:0]        out_rintg_i,
  input  logic                         out_err_i,
  output logic                         spurious_rsp_o
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [CW-1:0] rr_sel, sel;
  logic          any_req;

  logic [CW-1:0] id_q [MAX_OUTSTANDING];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [OW-1:0] cnt_q;
  logic          full, empty, push, pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == OW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    int unsigned   idx;
    logic [CW-1:0] cidx;
    rr_sel  = rr_q;
    any_req = 1'b0;
    idx     = 0;
    cidx    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx  = (int'(rr_q) + i) % NUM_CH;
      cidx = CW'(idx);
      if (!any_req && ch_req_i[cidx]) begin
        any_req = 1'b1;
        rr_sel  = cidx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_d      = rr_q;
    sel       = rr_sel;
    out_req_o = 1'b0;
    ch_gnt_o  = '0;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel       = rr_sel;
        out_req_o = any_req & ~full;
      end
      LOCKED: begin
        // Held until grant even if upstream drops req.
        sel       = lock_ch_q;
        out_req_o = 1'b1;
      end
    endcase
    if (out_req_o) begin
      if (out_gnt_i) begin
        push          = 1'b1;
        ch_gnt_o[sel] = 1'b1;
        rr_d          = (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        state_d       = IDLE;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = sel;
      end
    end
  end

  always_comb begin
    out_addr_o  = ch_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    out_we_o    = ch_we_i[sel];
    out_be_o    = ch_be_i[int'(sel)*BW +: BW];
    out_wdata_o = ch_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    out_wintg_o = ch_wintg_i[int'(sel)*INTG_WIDTH +: INTG_WIDTH];
  end

  // A same-cycle push is not visible here: pop needs an older entry.
  assign pop = out_rvalid_i & ~empty;

  always_comb begin
    ch_rvalid_o = '0;
    if (pop) ch_rvalid_o[id_q[rptr_q]] = 1'b1;
  end

  assign ch_rdata_o = out_rdata_i;
  assign ch_rintg_o = out_rintg_i;
  assign ch_err_o   = out_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      rr_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) id_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_q      <= rr_d;
      if (push) begin
        id_q[wptr_q] <= sel;
        wptr_q       <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef IBEX_MEM_ARB_SPURIOUS_CHK_EN
  logic spur_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) spur_q <= 1'b0;
    else if (out_rvalid_i && empty) spur_q <= 1'b1;
  end

  assign spurious_rsp_o = spur_q;

  spurious_rsp_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(out_rvalid_i && empty)
  ) else $error("rvalid with no outstanding request");
`else
  assign spurious_rsp_o = 1'b0;
`endif

endmodule
